snake_grid_writer: RTL

- Upstream producer for the 16x16 grid RAM (4-bit cell, address {x,y}, one write port, synchronous read).
- Owns snake state: clears the board, seeds the initial snake, and on each game-tick step moves the head, detects food and collisions, and erases the tail.
- Drives the RAM's write/address/data_in pins and reads its data_out.
- The game controller issues step/init; food placement is outside this block.

---
 rtl/snake_pkg.sv | 54 +++++
 rtl/snake_seg_fifo.sv | 64 ++++++
 rtl/snake_grid_writer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell codes, directions, FSM states and coordinate type for the snake grid writer
// Purpose: common definitions imported by snake_grid_writer and snake_seg_fifo.
// Ports: none (package).
package snake_pkg;

    // Cell codes stored in the 4-bit grid RAM; anything from 4 upward is treated as wall.
    localparam logic [3:0] CELL_EMPTY = 4'd0;
    localparam logic [3:0] CELL_BODY  = 4'd1;
    localparam logic [3:0] CELL_HEAD  = 4'd2;
    localparam logic [3:0] CELL_FOOD  = 4'd3;
    localparam logic [3:0] CELL_WALL  = 4'd4;

    // Direction encoding; the reverse of any direction is that direction xor 2.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // FSM states.
    localparam logic [3:0] ST_CLEAR = 4'd0;
    localparam logic [3:0] ST_SEED  = 4'd1;
    localparam logic [3:0] ST_IDLE  = 4'd2;
    localparam logic [3:0] ST_RD    = 4'd3;
    localparam logic [3:0] ST_CHK   = 4'd4;
    localparam logic [3:0] ST_WB    = 4'd5;
    localparam logic [3:0] ST_WH    = 4'd6;
    localparam logic [3:0] ST_ET    = 4'd7;
    localparam logic [3:0] ST_DEAD  = 4'd8;

    // Grid coordinate; packs to the RAM address {x,y}.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    // One cell in direction d with 4-bit wrap on both axes.
    function automatic coord_t coord_step(input coord_t c, input logic [1:0] d);
        coord_t n;
        n = c;
        case (d)
            DIR_UP:    n.y = c.y - 4'd1;
            DIR_RIGHT: n.x = c.x + 4'd1;
            DIR_DOWN:  n.y = c.y + 4'd1;
            default:   n.x = c.x - 4'd1;
        endcase
        return n;
    endfunction

    // Body, head and every wall code kill the snake; only empty and food are enterable.
    function automatic logic cell_blocks(input logic [3:0] code);
        return (code != CELL_EMPTY) && (code != CELL_FOOD);
    endfunction

endpackage

// File: rtl/snake_seg_fifo.sv
// rtl/snake_seg_fifo.sv - circular buffer of snake body coordinates, tail at the read side
// Purpose: holds the snake segments in order; the newest entry is the head, the oldest the tail.
// Ports:
//   clk, rst          clock and synchronous active-high reset (empties the buffer)
//   i_flush           empties the buffer (game restart)
//   i_push, i_push_data  append a coordinate at the head side
//   i_pop             drop the tail entry; push and pop together are legal even when full
//   o_head_q          most recently pushed coordinate
//   o_tail_q          oldest coordinate
//   o_count           number of stored coordinates
module snake_seg_fifo #(
    parameter int MAX_LEN = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [7:0]                   i_push_data,
    input  logic                         i_pop,
    output logic [7:0]                   o_head_q,
    output logic [7:0]                   o_tail_q,
    output logic [$clog2(MAX_LEN):0]     o_count
);
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    r_mem [MAX_LEN];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_last_ptr;

    assign w_last_ptr = r_wr_ptr - AW'(1);
    assign o_head_q   = r_mem[w_last_ptr];
    assign o_tail_q   = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage needs no reset; pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/snake_grid_writer.sv
// rtl/snake_grid_writer.sv - owns the snake on the 16x16 grid RAM: clear, seed, step, collide, erase
// Purpose: drives the grid RAM write port and reads it back to move the snake one cell per step.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   init              restart pulse (clear + seed), wins over everything
//   step, dir         advance request and requested direction (0 up,1 right,2 down,3 left)
//   busy              high except in IDLE and DEAD
//   done, ate, dead   step/seed completion pulse, food-eaten pulse, sticky collision flag
//   length            current snake length
//   ram_write, ram_x, ram_y, ram_din  RAM write/address/data pins
//   ram_dout          RAM read data, one cycle after the address
module snake_grid_writer
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int LEN_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic [1:0]       dir,
    output logic             busy,
    output logic             done,
    output logic             dead,
    output logic             ate,
    output logic [LEN_W-1:0] length,
    output logic             ram_write,
    output logic [3:0]       ram_x,
    output logic [3:0]       ram_y,
    output logic [3:0]       ram_din,
    input  logic [3:0]       ram_dout
);
    localparam int CW = $clog2(MAX_LEN) + 1;

    logic [3:0]       r_state;
    logic [7:0]       r_cnt;
    logic [1:0]       r_dir;
    coord_t           r_new;
    coord_t           r_tail;
    logic             r_food;
    logic             r_erase;
    logic             r_done;
    logic             r_ate;
    logic             r_dead;
    logic [LEN_W-1:0] r_len;

    coord_t           w_head;
    coord_t           w_tail;
    coord_t           w_seed;
    coord_t           w_push_data;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_seed_last;
    logic             w_fatal;
    logic [1:0]       w_next_dir;
    logic             w_write;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic [3:0]       w_din;

    // Seed cells run left to right ending at (8,8), so the tail goes in first.
    assign w_seed      = {4'(9 - INIT_LEN) + r_cnt[3:0], 4'd8};
    assign w_seed_last = (r_cnt == 8'(INIT_LEN - 1));

    // A request to reverse would fold the snake onto itself; keep going straight instead.
    assign w_next_dir  = (dir == (r_dir ^ 2'b10)) ? r_dir : dir;

    // Collision is reported in the same cycle the read data arrives.
    assign w_fatal     = (r_state == ST_CHK) && cell_blocks(ram_dout);

    // The new head is pushed in WH; when not growing the tail is popped in that
    // same cycle (latched into r_tail first) so a full buffer never overflows.
    assign w_push      = (r_state == ST_SEED) || (r_state == ST_WH);
    assign w_pop       = (r_state == ST_WH) && r_erase;
    assign w_push_data = (r_state == ST_SEED) ? w_seed : r_new;

    snake_seg_fifo #(
        .MAX_LEN(MAX_LEN)
    ) u_seg_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (init),
        .i_push     (w_push),
        .i_push_data(w_push_data),
        .i_pop      (w_pop),
        .o_head_q   (w_head),
        .o_tail_q   (w_tail),
        .o_count    (w_count)
    );

    // RAM pins follow the state directly so each state's access lands on its own cycle.
    always_comb begin
        w_write = 1'b0;
        w_x     = 4'd0;
        w_y     = 4'd0;
        w_din   = CELL_EMPTY;
        case (r_state)
            ST_CLEAR: begin
                w_write    = 1'b1;
                {w_x, w_y} = r_cnt;
            end
            ST_SEED: begin
                w_write    = 1'b1;
                {w_x, w_y} = w_seed;
                w_din      = w_seed_last ? CELL_HEAD : CELL_BODY;
            end
            ST_RD, ST_CHK: begin
                {w_x, w_y} = r_new;
            end
            ST_WB: begin
                w_write    = 1'b1;
                {w_x, w_y} = w_head;
                w_din      = CELL_BODY;
            end
            ST_WH: begin
                w_write    = 1'b1;
                {w_x, w_y} = r_new;
                w_din      = CELL_HEAD;
            end
            ST_ET: begin
                w_write    = r_erase;
                {w_x, w_y} = r_tail;
            end
            default: ;
        endcase
    end

    // Write enable is held low while reset is asserted.
    assign ram_write = w_write & ~rst;
    assign ram_x     = w_x;
    assign ram_y     = w_y;
    assign ram_din   = w_din;

    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DEAD);
    assign done      = r_done | w_fatal;
    assign ate       = r_ate;
    assign dead      = r_dead;
    assign length    = r_len;

    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        r_ate  <= 1'b0;
        if (rst || init) begin
            r_state <= ST_CLEAR;
            r_cnt   <= 8'd0;
            r_dir   <= DIR_RIGHT;
            r_new   <= '0;
            r_tail  <= '0;
            r_food  <= 1'b0;
            r_erase <= 1'b0;
            r_dead  <= 1'b0;
            r_len   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd255) begin
                        r_state <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_seed_last) begin
                        r_len   <= LEN_W'(INIT_LEN);
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (step) begin
                        r_dir   <= w_next_dir;
                        r_new   <= coord_step(w_head, w_next_dir);
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_CHK;
                end
                ST_CHK: begin
                    if (cell_blocks(ram_dout)) begin
                        r_dead  <= 1'b1;
                        r_state <= ST_DEAD;
                    end else begin
                        r_food  <= (ram_dout == CELL_FOOD);
                        // Growth only while the segment buffer has room.
                        r_erase <= !((ram_dout == CELL_FOOD) && (w_count < CW'(MAX_LEN)));
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    r_state <= ST_WH;
                end
                ST_WH: begin
                    r_tail  <= w_tail;
                    r_state <= ST_ET;
                end
                ST_ET: begin
                    if (!r_erase) begin
                        r_len <= r_len + LEN_W'(1);
                    end
                    r_done  <= 1'b1;
                    r_ate   <= r_food;
                    r_state <= ST_IDLE;
                end
                ST_DEAD: begin
                    r_state <= ST_DEAD;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule
